bpsk_modulator: RTL
===================

// Module: bpsk_modulator
// PURPOSE
//   Transmit-side stage that feeds the receiver's signed 8-bit sample input.
//   - Accepts bytes over a valid/ready handshake.
//   - Wraps each byte in a frame: preamble, then sync word, then data, all MSB first.
//   - Emits one BPSK carrier sample per sample strobe: bit 1 = +sine, bit 0 = -sine, idle = 0.
// PARAMETERS
//   CYCLES_PER_BIT  4      carrier cycles per symbol; 1..64
//   PREAMBLE_BITS   8      alternating 1,0,1,0.. bits before sync; even, 2..32
//   SYNC_WORD       8'hD5  8-bit frame marker sent after preamble, MSB first
// PORTS
//   clock         in   1  system clock, all state on rising edge
//   reset_n       in   1  asynchronous active-low reset
//   sample_en     in   1  one-cycle strobe; advances modulator by one sample
//   data_in       in   8  byte to transmit
//   data_valid    in   1  data_in is valid
//   data_ready    out  1  block can accept a byte (combinational: state==IDLE)
//   signal        out  8  signed carrier sample (registered)
//   sample_valid  out  1  pulses one cycle after each sample_en (registered)
//   busy          out  1  high while a frame is in progress (state!=IDLE)
// BEHAVIOUR
//   Reset values: state=IDLE, signal=0, sample_valid=0, busy=0, data_ready=1, all counters=0.
//   Handshake:
//     - Transfer when data_valid && data_ready on a clock edge.
//     - data_in is latched into shift_reg at that edge; state becomes PREAMBLE.
//     - data_ready is low for the whole frame. data_in is ignored outside transfer edges.
//   Sine LUT: 16 samples per carrier cycle, k = phase[3:0]:
//     - 0,49,90,117,127,117,90,49,0,-49,-90,-117,-127,-117,-90,-49
//     - Bit 0 output = two's-complement negation of the LUT entry; values never exceed +/-127.
//   Counters:
//     - phase (4b) and cyc_cnt (6b) advance only on sample_en.
//     - phase wraps 15->0; cyc_cnt increments at each wrap.
//     - At cyc_cnt==CYCLES_PER_BIT-1 && phase==15: symbol ends, bit_cnt increments, cyc_cnt=0.
//     - phase, cyc_cnt, bit_cnt are cleared at the transfer edge, so every frame starts at phase 0.
//   FSM:
//     - IDLE     : signal<=0 on each sample_en. Transfer -> PREAMBLE.
//     - PREAMBLE : current bit = ~bit_cnt[0] (first bit 1).
//                  After PREAMBLE_BITS symbols -> SYNC; bit_cnt=0.
//     - SYNC     : current bit = SYNC_WORD[7-bit_cnt]. After 8 symbols -> DATA; bit_cnt=0.
//     - DATA     : current bit = shift_reg[7-bit_cnt]. After 8 symbols -> IDLE.
//   Sample timing:
//     - On a sample_en edge: signal <= +/-LUT[phase] for the current bit; sample_valid <= 1.
//     - Otherwise sample_valid <= 0 and signal holds.
//     - Latency: sample appears one clock after its sample_en.
//     - A sample_en on the transfer edge is an IDLE sample (outputs 0).
//       The first preamble sample is produced by the next sample_en.
//   Frame length: (PREAMBLE_BITS+16)*CYCLES_PER_BIT*16 samples; 1536 at defaults.
//   Back-to-back frames:
//     - data_ready rises the clock after the last DATA sample_en.
//     - A waiting byte is accepted on that edge.
//     - No IDLE sample is inserted unless sample_en arrives first.
//   sample_en held high continuously: one sample per clock, no stall.
//   Reset mid-frame: immediately IDLE, signal=0, busy=0, data_ready=1. The frame is abandoned.
// TESTING
//   1. Reset, then byte 0x00, sample_en every clock.
//      -> Samples 0-63 follow +LUT (s0=0, s4=127).
//      -> Samples 64-127 follow -LUT (s68=-127).
//      -> Samples 1024-1535 all -LUT.
//      -> busy falls after sample 1535.
//   2. Byte 0xFF with sample_en every 5th clock.
//      -> 1536 sample_valid pulses, each exactly 1 clock after its strobe.
//      -> Data section = +LUT. Signal constant between strobes.
//   3. Sync check with default SYNC_WORD 0xD5, byte 0x5A.
//      -> Sign of symbols 8..15 = + + - + - + - +.
//      -> Sign of symbols 16..23 = - + - + + - + -.
//   4. data_valid held high with 0x11 then 0x22.
//      -> Exactly two transfers, frames contiguous.
//      -> 0x22 frame starts at phase 0, data_ready low for the whole frame.
//   5. Assert reset_n low at sample 700 of a frame.
//      -> signal=0, busy=0 asynchronously.
//      -> After release, a new byte produces a full 1536-sample frame from +LUT[0].
//   6. data_valid high together with sample_en while IDLE.
//      -> That strobe yields signal=0.
//      -> The next strobe yields +LUT[0]=0, then 49.

Source files
------------

// File: rtl/bpsk_modulator.sv
// BPSK frame modulator: wraps each accepted byte in preamble + sync word + data and emits
// one signed carrier sample per sample strobe (bit 1 = +sine, bit 0 = -sine, idle = 0).
module bpsk_modulator #(
  parameter int unsigned CyclesPerBit = 4,
  parameter int unsigned PreambleBits = 8,
  parameter logic [7:0]  SyncWord     = 8'hD5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sample_en_i,
  input  logic [7:0]        data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  output logic signed [7:0] signal_o,
  output logic              sample_valid_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StPreamble, StSync, StData} state_e;

  state_e             state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [3:0]         phase_q, phase_d;
  logic [5:0]         cyc_q, cyc_d;
  logic [4:0]         bit_q, bit_d;
  logic signed [7:0]  signal_q, signal_d;
  logic               sample_valid_q, sample_valid_d;

  logic               cur_bit;
  logic               last_bit;
  logic signed [7:0]  lut_val;

  function automatic logic signed [7:0] sine_lut(input logic [3:0] k);
    logic signed [7:0] v;
    case (k)
      4'd0:    v = 8'sd0;
      4'd1:    v = 8'sd49;
      4'd2:    v = 8'sd90;
      4'd3:    v = 8'sd117;
      4'd4:    v = 8'sd127;
      4'd5:    v = 8'sd117;
      4'd6:    v = 8'sd90;
      4'd7:    v = 8'sd49;
      4'd8:    v = 8'sd0;
      4'd9:    v = -8'sd49;
      4'd10:   v = -8'sd90;
      4'd11:   v = -8'sd117;
      4'd12:   v = -8'sd127;
      4'd13:   v = -8'sd117;
      4'd14:   v = -8'sd90;
      default: v = -8'sd49;
    endcase
    return v;
  endfunction

  assign lut_val = sine_lut(phase_q);

  // Current symbol bit and end-of-section detection for the active frame section.
  always_comb begin
    cur_bit  = 1'b0;
    last_bit = (bit_q == 5'd7);
    unique case (state_q)
      StPreamble: begin
        cur_bit  = ~bit_q[0];
        last_bit = (bit_q == 5'(PreambleBits - 1));
      end
      StSync:     cur_bit = SyncWord[3'd7 - bit_q[2:0]];
      StData:     cur_bit = shift_q[3'd7 - bit_q[2:0]];
      default:    cur_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    phase_d        = phase_q;
    cyc_d          = cyc_q;
    bit_d          = bit_q;
    signal_d       = signal_q;
    sample_valid_d = sample_en_i;

    if (state_q == StIdle) begin
      if (sample_en_i) begin
        signal_d = 8'sd0;
      end
      if (data_valid_i) begin
        state_d = StPreamble;
        shift_d = data_i;
        phase_d = 4'd0;
        cyc_d   = 6'd0;
        bit_d   = 5'd0;
      end
    end else if (sample_en_i) begin
      signal_d = cur_bit ? lut_val : -lut_val;
      phase_d  = phase_q + 4'd1;
      if (phase_q == 4'd15) begin
        if (cyc_q == 6'(CyclesPerBit - 1)) begin
          cyc_d = 6'd0;
          if (last_bit) begin
            bit_d = 5'd0;
            unique case (state_q)
              StPreamble: state_d = StSync;
              StSync:     state_d = StData;
              default:    state_d = StIdle;
            endcase
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end else begin
          cyc_d = cyc_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      shift_q        <= 8'd0;
      phase_q        <= 4'd0;
      cyc_q          <= 6'd0;
      bit_q          <= 5'd0;
      signal_q       <= 8'sd0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      phase_q        <= phase_d;
      cyc_q          <= cyc_d;
      bit_q          <= bit_d;
      signal_q       <= signal_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign data_ready_o   = (state_q == StIdle);
  assign busy_o         = (state_q != StIdle);
  assign signal_o       = signal_q;
  assign sample_valid_o = sample_valid_q;

endmodule
